// File: rtl/mux8b_src_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux8b_src_arb_pkg
//  Shared constants for the mux8b source arbiter.
//  SEL_A / SEL_B : values of Sel (and of rr_last) that name channel A / B.
//  state_t       : output-stage occupancy (ST_EMPTY / ST_FULL).
// -----------------------------------------------------------------------------
package mux8b_src_arb_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux8b_src_arb_if.sv
// -----------------------------------------------------------------------------
// mux8b_src_arb_if
//  Bundle of the producer channels, the mux8b operand/select outputs and the
//  consumer handshake.
//  Signals:
//   a_in/a_valid/a_ready  channel A producer handshake
//   b_in/b_valid/b_ready  channel B producer handshake
//   A, B, Sel             registered operands and select towards mux8b
//   out_valid/out_ready   consumer handshake for the mux8b output F
//  Modports:
//   master : the arbiter (drives readies, operands, Sel, out_valid)
//   slave  : the environment (producers and consumer)
// -----------------------------------------------------------------------------
interface mux8b_src_arb_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] a_in;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_in;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sel;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  a_in, a_valid, b_in, b_valid, out_ready,
        output a_ready, b_ready, A, B, Sel, out_valid
    );

    modport slave (
        output a_in, a_valid, b_in, b_valid, out_ready,
        input  a_ready, b_ready, A, B, Sel, out_valid
    );

endinterface

// File: rtl/mux8b_src_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//  Two-way round-robin arbiter, purely combinational.
//  Ports:
//   req[1:0] in   request per channel (bit 0 = A, bit 1 = B)
//   rr_last  in   channel granted by the last real transfer (SEL_A / SEL_B)
//   en       in   grant allowed this cycle
//   gnt[1:0] out  one-hot grant, or zero
// -----------------------------------------------------------------------------
module rr_arb2
    import mux8b_src_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: the channel that did not win last time goes first.
                2'b11:   gnt = (rr_last == SEL_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mux8b_src_arb.sv
// -----------------------------------------------------------------------------
// mux8b_src_arb
//  Source stage in front of mux8b. Arbitrates channels A and B round-robin,
//  captures the winning byte into the A or B operand register and sets Sel so
//  that mux8b's F shows the granted byte. A one-entry output stage
//  (out_valid/out_ready) lets the consumer of F stall the pipe.
//  Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    master modport of mux8b_src_arb_if (handshakes, A, B, Sel)
// -----------------------------------------------------------------------------
module mux8b_src_arb
    import mux8b_src_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
)(
    input  logic           clk,
    input  logic           rst_n,
    mux8b_src_arb_if.master bus
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sel_reg;
    logic             rr_last_reg;

    logic             can_load;
    logic [1:0]       gnt;
    logic             xfer_a;
    logic             xfer_b;

    // The slot can take a new byte when empty, or when the held byte leaves now.
    assign can_load = (state_reg == ST_EMPTY) | bus.out_ready;

    rr_arb2 u_rr_arb2 (
        .req     ({bus.b_valid, bus.a_valid}),
        .rr_last (rr_last_reg),
        .en      (can_load),
        .gnt     (gnt)
    );

    // A grant is only issued for a valid request, so a grant is a transfer.
    assign xfer_a = gnt[0];
    assign xfer_b = gnt[1];

    assign bus.a_ready   = xfer_a;
    assign bus.b_ready   = xfer_b;
    assign bus.A         = a_reg;
    assign bus.B         = b_reg;
    assign bus.Sel       = sel_reg;
    assign bus.out_valid = (state_reg == ST_FULL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_EMPTY: begin
                if (xfer_a | xfer_b) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                // Without out_ready no grant can occur, so the slot holds.
                if (bus.out_ready) begin
                    state_next = (xfer_a | xfer_b) ? ST_FULL : ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Operand, select and round-robin history. The operand of the channel
    // that did not transfer keeps its stale value; Sel alone marks validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            sel_reg     <= SEL_A;
            rr_last_reg <= SEL_B;
        end else begin
            if (xfer_a) begin
                a_reg       <= bus.a_in;
                sel_reg     <= SEL_A;
                rr_last_reg <= SEL_A;
            end else if (xfer_b) begin
                b_reg       <= bus.b_in;
                sel_reg     <= SEL_B;
                rr_last_reg <= SEL_B;
            end
        end
    end

endmodule
